elevator_ctrl_module: RTL and testbench
=======================================

# elevator_ctrl_module

Car-motion controller for the 4-floor elevator. Consumes the position-relative request vectors from `button_module`: bit 0 = call at current floor, bit 1 = any call above, bit 2 = any call below. It owns the car position register, runs the up/down sweep state machine, and times travel and door-open intervals. Its `open` and `position` outputs drive `reg_button_in_module` and `button_module`, which closes the request loop.

## Interface
- `TRAVEL_CYCLES`, default 8: clock cycles to move one floor; legal range is 1..255.
- `DOOR_CYCLES`, default 4: clock cycles the door stays open per service; legal range is 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces the reset state immediately.
- `ctrl_button_up` in 3: hall-up request vector {below, above, here}.
- `ctrl_button_down` in 3: hall-down request vector {below, above, here}.
- `ctrl_button_in` in 3: in-car request vector {below, above, here}.
- `position` out 2: current floor, 0..3; registered.
- `open` out 1: door open; registered.
- `moving` out 1: car between floors; registered.
- `dir_up` out 1: sweep direction, 1 = up; registered.

## Operation
- Derived signals:
  - here_any = in[0] | up[0] | down[0]
  - above_any = in[1] | up[1] | down[1]
  - below_any = in[2] | up[2] | down[2]
  - here_dir = in[0] | (dir_up ? up[0] : down[0])
- States: IDLE, MOVE_UP, MOVE_DOWN, ARRIVE, DOOR_OPEN.
- IDLE, evaluated every cycle; the first matching rule wins:
  1. here_any → DOOR_OPEN.
  2. Call in the current direction (above_any if dir_up, else below_any) → MOVE in that direction.
  3. Call in the opposite direction → flip dir_up, then MOVE.
  4. Otherwise stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - Load the timer with TRAVEL_CYCLES-1 on entry; `moving`=1.
  - When the timer reaches 0, position ±1 and go to ARRIVE.
  - MOVE_UP is never entered when position=3, and MOVE_DOWN never when position=0. If the vector is inconsistent there, stay in IDLE.
- ARRIVE lasts one cycle, with `moving`=0. It uses the request vectors already re-encoded for the new position:
  - here_dir → DOOR_OPEN.
  - Else a further call in the current direction → continue MOVE in the same direction (pass-through floor).
  - Else here_any (opposite-direction hall call only) → flip dir_up, DOOR_OPEN.
  - Else → IDLE.
- DOOR_OPEN:
  - `open`=1; load the timer with DOOR_CYCLES-1 on entry.
  - When the timer reaches 0 → IDLE with `open`=0.
  - New here-calls while the door is open do not extend the interval. IDLE re-opens the door on the following cycle if a here-call remains.
- Requests change asynchronously with respect to the controller. Every decision uses the vector values sampled at the deciding edge.

## Timing
- Reset values: position=0, open=0, moving=0, dir_up=1, state=IDLE, timer=0.
- IDLE decision to `open` rising: 1 cycle.
- `open` stays high for exactly DOOR_CYCLES cycles.
- MOVE entry to position update: TRAVEL_CYCLES cycles.
- Floor-to-floor time when passing a floor: TRAVEL_CYCLES+1 cycles, including ARRIVE.
- Reset asserted mid-travel or with the door open: outputs go to reset values asynchronously, and the car is considered at floor 0. Outstanding requests are re-served after release.
- Reset release: first decision on the first clock edge with reset low.
- Position never wraps. Increment at 3 and decrement at 0 are unreachable; an assertion guards both.

## Structure
- Package `elevator_pkg`:
  - state enum (5 states);
  - bit-index constants REQ_HERE=0, REQ_ABOVE=1, REQ_BELOW=2;
  - NUM_FLOORS=4 and POS_W=2;
  - timer width TMR_W=8.
- Sub-module `cycle_timer`: 8-bit down-counter with `load`, `load_val` and `expired` (count==0), with asynchronous active-high reset. A single instance is shared by the travel and door intervals.
- `elevator_ctrl_module` contains the state register, position register, direction flag and next-state logic.

## Test plan
- Reset, then in[0]=1 at floor 0 → `open`=1 starting 1 cycle later, held 4 cycles; position stays 0.
- Car call to floor 2 from floor 0 (in[1]=1 until position=2, then in[0]=1):
  - position 0→1 after 8 cycles;
  - ARRIVE passes floor 1;
  - position=2 nine cycles later;
  - `open` pulses for 4 cycles.
- At floor 1 moving up, with down[0]=1 at floor 1 and in[1]=1 pending → no stop at 1; continue to the upper call.
- At floor 3 with only a below call → dir_up flips to 0, MOVE_DOWN, position decrements.
- Assert reset during MOVE_UP mid-timer at floor 2 → position=0, moving=0, open=0 immediately. After release, the pending request is re-served from floor 0.
- Door open at floor 1 and in[0] re-asserted mid-interval → `open` drops after 4 cycles, then re-asserts after 1 cycle.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the 4-floor elevator car controller.
package elevator_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        ARRIVE,
        DOOR_OPEN
    } state_e;

    localparam int REQ_HERE   = 0;
    localparam int REQ_ABOVE  = 1;
    localparam int REQ_BELOW  = 2;

    localparam int NUM_FLOORS = 4;
    localparam int POS_W      = 2;
    localparam int TMR_W      = 8;

endpackage

// File: rtl/elevator_ctrl_module_cycle_timer.sv
// Loadable down-counter shared by the travel and door intervals; holds at zero.
module cycle_timer
    import elevator_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             expired
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/elevator_ctrl_module.sv
// Car-motion controller: up/down sweep FSM, car position and travel/door timing.
module elevator_ctrl_module
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       ctrl_button_up,
    input  logic [2:0]       ctrl_button_down,
    input  logic [2:0]       ctrl_button_in,
    output logic [POS_W-1:0] position,
    output logic             open,
    output logic             moving,
    output logic             dir_up
);

    localparam logic [TMR_W-1:0] TRAVEL_LD = TMR_W'(TRAVEL_CYCLES - 1);
    localparam logic [TMR_W-1:0] DOOR_LD   = TMR_W'(DOOR_CYCLES - 1);
    localparam logic [POS_W-1:0] TOP_FLOOR = POS_W'(NUM_FLOORS - 1);

    state_e           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             open_q, moving_q;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expired;

    logic here_any, above_any, below_any, here_dir;
    logic above_ok, below_ok, fwd_ok, rev_ok;

    cycle_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_comb begin
        here_any  = ctrl_button_in[REQ_HERE]  | ctrl_button_up[REQ_HERE]  | ctrl_button_down[REQ_HERE];
        above_any = ctrl_button_in[REQ_ABOVE] | ctrl_button_up[REQ_ABOVE] | ctrl_button_down[REQ_ABOVE];
        below_any = ctrl_button_in[REQ_BELOW] | ctrl_button_up[REQ_BELOW] | ctrl_button_down[REQ_BELOW];
        here_dir  = ctrl_button_in[REQ_HERE]  |
                    (dir_q ? ctrl_button_up[REQ_HERE] : ctrl_button_down[REQ_HERE]);
        // An "above" call at the top floor (or "below" at floor 0) is inconsistent and ignored.
        above_ok  = above_any && (pos_q != TOP_FLOOR);
        below_ok  = below_any && (pos_q != '0);
        fwd_ok    = dir_q ? above_ok : below_ok;
        rev_ok    = dir_q ? below_ok : above_ok;
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        tmr_load = 1'b0;
        tmr_val  = TRAVEL_LD;
        unique case (state_q)
            IDLE: begin
                if (here_any) begin
                    state_d  = DOOR_OPEN;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LD;
                end else if (fwd_ok) begin
                    state_d  = dir_q ? MOVE_UP : MOVE_DOWN;
                    tmr_load = 1'b1;
                end else if (rev_ok) begin
                    dir_d    = ~dir_q;
                    state_d  = dir_q ? MOVE_DOWN : MOVE_UP;
                    tmr_load = 1'b1;
                end
            end
            MOVE_UP: begin
                if (tmr_expired) begin
                    pos_d   = pos_q + POS_W'(1);
                    state_d = ARRIVE;
                end
            end
            MOVE_DOWN: begin
                if (tmr_expired) begin
                    pos_d   = pos_q - POS_W'(1);
                    state_d = ARRIVE;
                end
            end
            ARRIVE: begin
                if (here_dir) begin
                    state_d  = DOOR_OPEN;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LD;
                end else if (fwd_ok) begin
                    state_d  = dir_q ? MOVE_UP : MOVE_DOWN;
                    tmr_load = 1'b1;
                end else if (here_any) begin
                    dir_d    = ~dir_q;
                    state_d  = DOOR_OPEN;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LD;
                end else begin
                    state_d  = IDLE;
                end
            end
            DOOR_OPEN: begin
                if (tmr_expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pos_q    <= '0;
            dir_q    <= 1'b1;
            open_q   <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            open_q   <= (state_d == DOOR_OPEN);
            moving_q <= (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
        end
    end

    assign position = pos_q;
    assign open     = open_q;
    assign moving   = moving_q;
    assign dir_up   = dir_q;

    a_no_wrap_up: assert property (@(posedge clk) disable iff (reset)
        (state_q == MOVE_UP && tmr_expired) |-> (pos_q != TOP_FLOOR));
    a_no_wrap_down: assert property (@(posedge clk) disable iff (reset)
        (state_q == MOVE_DOWN && tmr_expired) |-> (pos_q != '0));

endmodule

// File: tb/tb_elevator_ctrl_module.sv
// Directed bench for elevator_ctrl_module; request vectors are encoded from per-floor request sets.
module tb_elevator_ctrl_module;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] ctrl_button_up, ctrl_button_down, ctrl_button_in;
    logic [1:0] position;
    logic       open, moving, dir_up;

    logic [3:0] car_req, up_req, down_req;
    logic       raw_mode;
    logic [2:0] raw_in;
    logic       open_prev;

    int n_checks = 0;
    int n_errors = 0;

    elevator_ctrl_module #(.TRAVEL_CYCLES(8), .DOOR_CYCLES(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .ctrl_button_up   (ctrl_button_up),
        .ctrl_button_down (ctrl_button_down),
        .ctrl_button_in   (ctrl_button_in),
        .position         (position),
        .open             (open),
        .moving           (moving),
        .dir_up           (dir_up)
    );

    always #5 clk = ~clk;

    // Position-relative encoding {below, above, here}, as button_module would produce.
    always_comb begin
        logic [2:0] v_in, v_up, v_dn;
        v_in = '0;
        v_up = '0;
        v_dn = '0;
        for (int f = 0; f < 4; f++) begin
            if (car_req[f])  v_in[(f == int'(position)) ? 0 : (f > int'(position)) ? 1 : 2] = 1'b1;
            if (up_req[f])   v_up[(f == int'(position)) ? 0 : (f > int'(position)) ? 1 : 2] = 1'b1;
            if (down_req[f]) v_dn[(f == int'(position)) ? 0 : (f > int'(position)) ? 1 : 2] = 1'b1;
        end
        ctrl_button_in   = raw_mode ? raw_in : v_in;
        ctrl_button_up   = raw_mode ? 3'b000 : v_up;
        ctrl_button_down = raw_mode ? 3'b000 : v_dn;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge and clear served requests when the door opens.
    task automatic tick();
        @(posedge clk);
        #1;
        if (open && !open_prev) begin
            car_req[position]  = 1'b0;
            up_req[position]   = 1'b0;
            down_req[position] = 1'b0;
        end
        open_prev = open;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        open_prev = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        car_req = '0; up_req = '0; down_req = '0;
        raw_mode = 1'b0; raw_in = '0; open_prev = 1'b0;
        tick(); tick();
        chk("rst_pos", position, 0);
        chk("rst_open", open, 0);
        chk("rst_moving", moving, 0);
        chk("rst_dir", dir_up, 1);
        reset = 1'b0;

        // Here-call at floor 0: door opens next cycle for exactly 4 cycles.
        car_req[0] = 1'b1;
        tick();
        chk("t1_open_rise", open, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_open_held", open, 1);
        end
        tick();
        chk("t1_open_fall", open, 0);
        chk("t1_pos", position, 0);

        // Inconsistent "below" vector at floor 0 must not move the car.
        raw_mode = 1'b1; raw_in = 3'b100;
        ticks(3);
        chk("bnd_below0_moving", moving, 0);
        chk("bnd_below0_pos", position, 0);
        chk("bnd_below0_dir", dir_up, 1);
        raw_mode = 1'b0; raw_in = '0;

        // Car call to floor 2, passing floor 1.
        car_req[2] = 1'b1;
        tick();
        chk("t2_moving", moving, 1);
        ticks(7);
        chk("t2_pos_before", position, 0);
        tick();
        chk("t2_pos1", position, 1);
        chk("t2_arrive_moving", moving, 0);
        tick();
        chk("t2_pass_moving", moving, 1);
        chk("t2_pass_open", open, 0);
        ticks(7);
        chk("t2_pos1_hold", position, 1);
        tick();
        chk("t2_pos2", position, 2);
        tick();
        chk("t2_open", open, 1);
        ticks(3);
        chk("t2_open_held", open, 1);
        tick();
        chk("t2_open_fall", open, 0);

        // Opposite-direction hall call at floor 1 is passed on the way up to floor 3.
        do_reset();
        down_req[1] = 1'b1;
        car_req[3]  = 1'b1;
        tick();
        ticks(8);
        chk("t3_pos1", position, 1);
        tick();
        chk("t3_no_stop_moving", moving, 1);
        chk("t3_no_stop_open", open, 0);
        for (int i = 0; i < 30 && position != 2'd3; i++) tick();
        chk("t3_pos3", position, 3);
        tick();
        chk("t3_open3", open, 1);
        ticks(3);
        tick();
        chk("t3_close3", open, 0);

        // At floor 3 with only a below call: direction flips and the car descends.
        tick();
        chk("t4_dir_flip", dir_up, 0);
        chk("t4_moving", moving, 1);
        ticks(8);
        chk("t4_pos2", position, 2);
        ticks(9);
        chk("t4_pos1", position, 1);
        tick();
        chk("t4_open1", open, 1);
        chk("t4_dir_down", dir_up, 0);
        ticks(3);
        tick();
        chk("t4_close1", open, 0);

        // Reset mid-travel from floor 2, then re-serve the pending call from floor 0.
        car_req[3] = 1'b1;
        tick();
        chk("t5_dir_up", dir_up, 1);
        ticks(8);
        chk("t5_pos2", position, 2);
        tick();
        ticks(3);
        chk("t5_mid_moving", moving, 1);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_pos", position, 0);
        chk("t5_rst_moving", moving, 0);
        chk("t5_rst_open", open, 0);
        #1 reset = 1'b0;
        open_prev = 1'b0;
        tick();
        chk("t5_reserve_moving", moving, 1);
        chk("t5_reserve_pos", position, 0);
        for (int i = 0; i < 40 && position != 2'd3; i++) tick();
        chk("t5_pos3", position, 3);
        tick();
        chk("t5_open3", open, 1);
        ticks(4);
        chk("t5_close3", open, 0);

        // Here-call re-asserted while the door is open: no extension, re-open one cycle later.
        do_reset();
        car_req[1] = 1'b1;
        for (int i = 0; i < 20 && !open; i++) tick();
        chk("t6_open", open, 1);
        chk("t6_pos", position, 1);
        tick();
        car_req[1] = 1'b1;
        ticks(2);
        chk("t6_open_c4", open, 1);
        tick();
        chk("t6_open_fall", open, 0);
        tick();
        chk("t6_reopen", open, 1);
        chk("t6_reopen_pos", position, 1);
        ticks(4);
        chk("t6_close", open, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
